// File: rtl/decode_hazard_ctrl_if.sv
// Decode-stage hazard interface: register usage and timing of the instruction in D,
// plus the stall, flush and forwarding controls returned by the hazard controller.
interface decode_hazard_ctrl_if;
  logic [4:0] rs_D;
  logic [4:0] rt_D;
  logic [1:0] Tuse_rs_D;
  logic [1:0] Tuse_rt_D;
  logic [4:0] WriteReg_D;
  logic [1:0] Tnew_D;
  logic       LinkSrc_D;
  logic       MD_Start_D;
  logic       MD_Div_D;
  logic       MD_Use_D;
  logic       Stall_D;
  logic       FlushE;
  logic [1:0] MUX_RS_D_Sel;
  logic [1:0] MUX_RT_D_Sel;
  logic       MDBusy;

  modport master (
    output rs_D, rt_D, Tuse_rs_D, Tuse_rt_D, WriteReg_D, Tnew_D, LinkSrc_D,
    output MD_Start_D, MD_Div_D, MD_Use_D,
    input  Stall_D, FlushE, MUX_RS_D_Sel, MUX_RT_D_Sel, MDBusy
  );

  modport slave (
    input  rs_D, rt_D, Tuse_rs_D, Tuse_rt_D, WriteReg_D, Tnew_D, LinkSrc_D,
    input  MD_Start_D, MD_Div_D, MD_Use_D,
    output Stall_D, FlushE, MUX_RS_D_Sel, MUX_RT_D_Sel, MDBusy
  );
endinterface

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard controller: Tnew/Tuse scoreboard, D-stage forwarding and MDU busy window.
// Optional HAZARD_STAT_EN adds a saturating stall-cycle counter output stall_cnt.
module decode_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input logic                 CLK,
  input logic                 RESET,
  decode_hazard_ctrl_if.slave bus
`ifdef HAZARD_STAT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  // E and M scoreboard slots. W-stage results reach D through register-file
  // write-through, so nothing downstream of M is needed to make decisions.
  logic [4:0]       e_addr_q, m_addr_q;
  logic [1:0]       e_tnew_q, m_tnew_q;
  logic             e_link_q, m_link_q;
  logic             start_e_q;
  logic             md_div_q;
  logic [CNT_W-1:0] cnt_q;

  logic stall_rs, stall_rt, stall_md, stall;

  always_comb begin
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    if (bus.rs_D != 5'd0) begin
      stall_rs = ((bus.rs_D == e_addr_q) && (bus.Tuse_rs_D < e_tnew_q)) ||
                 ((bus.rs_D == m_addr_q) && (bus.Tuse_rs_D < m_tnew_q));
    end
    if (bus.rt_D != 5'd0) begin
      stall_rt = ((bus.rt_D == e_addr_q) && (bus.Tuse_rt_D < e_tnew_q)) ||
                 ((bus.rt_D == m_addr_q) && (bus.Tuse_rt_D < m_tnew_q));
    end
    stall_md = bus.MD_Use_D && ((cnt_q != '0) || start_e_q);
    stall    = stall_rs || stall_rt || stall_md;
  end

  // Only a ready (tnew==0) result sitting in M is forwarded; select 3 is unused.
  always_comb begin
    bus.MUX_RS_D_Sel = 2'd0;
    bus.MUX_RT_D_Sel = 2'd0;
    if ((bus.rs_D != 5'd0) && (bus.rs_D == m_addr_q) && (m_tnew_q == 2'd0)) begin
      bus.MUX_RS_D_Sel = m_link_q ? 2'd2 : 2'd1;
    end
    if ((bus.rt_D != 5'd0) && (bus.rt_D == m_addr_q) && (m_tnew_q == 2'd0)) begin
      bus.MUX_RT_D_Sel = m_link_q ? 2'd2 : 2'd1;
    end
  end

  assign bus.Stall_D = stall;
  assign bus.FlushE  = stall;
  assign bus.MDBusy  = (cnt_q != '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      e_addr_q  <= 5'd0;
      e_tnew_q  <= 2'd0;
      e_link_q  <= 1'b0;
      m_addr_q  <= 5'd0;
      m_tnew_q  <= 2'd0;
      m_link_q  <= 1'b0;
      start_e_q <= 1'b0;
      md_div_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      m_addr_q <= e_addr_q;
      m_tnew_q <= (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
      m_link_q <= e_link_q;
      if (stall) begin
        e_addr_q <= 5'd0;
        e_tnew_q <= 2'd0;
        e_link_q <= 1'b0;
      end else begin
        e_addr_q <= bus.WriteReg_D;
        e_tnew_q <= bus.Tnew_D;
        e_link_q <= bus.LinkSrc_D;
      end
      // A start held in D by a stall is not recorded until it actually issues.
      start_e_q <= bus.MD_Start_D && !stall;
      md_div_q  <= bus.MD_Div_D;
      if (start_e_q) begin
        cnt_q <= md_div_q ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

`ifdef HAZARD_STAT_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cnt <= 32'd0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed self-checking bench for decode_hazard_ctrl: load-use, branch, link forwarding,
// MDU busy window, zero register, stalled start and mid-busy reset.
module tb_decode_hazard_ctrl;
  logic CLK;
  logic RESET;
  int   pass_cnt;
  int   total_cnt;

  decode_hazard_ctrl_if bus ();

`ifdef HAZARD_STAT_EN
  logic [31:0] stall_cnt;
`endif

  decode_hazard_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .CNT_W      (4)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
`ifdef HAZARD_STAT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic set_nop();
    bus.rs_D       = 5'd0;
    bus.rt_D       = 5'd0;
    bus.Tuse_rs_D  = 2'd3;
    bus.Tuse_rt_D  = 2'd3;
    bus.WriteReg_D = 5'd0;
    bus.Tnew_D     = 2'd0;
    bus.LinkSrc_D  = 1'b0;
    bus.MD_Start_D = 1'b0;
    bus.MD_Div_D   = 1'b0;
    bus.MD_Use_D   = 1'b0;
  endtask

  task automatic drain();
    set_nop();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    set_nop();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    #1;
    total_cnt++;
    if (bus.Stall_D !== 1'b0) $display("FAIL reset_stall got %b want 0", bus.Stall_D);
    else pass_cnt++;
    total_cnt++;
    if (bus.FlushE !== 1'b0) $display("FAIL reset_flush got %b want 0", bus.FlushE);
    else pass_cnt++;
    total_cnt++;
    if (bus.MUX_RS_D_Sel !== 2'd0) $display("FAIL reset_rs_sel got %0d want 0", bus.MUX_RS_D_Sel);
    else pass_cnt++;
    total_cnt++;
    if (bus.MUX_RT_D_Sel !== 2'd0) $display("FAIL reset_rt_sel got %0d want 0", bus.MUX_RT_D_Sel);
    else pass_cnt++;
    total_cnt++;
    if (bus.MDBusy !== 1'b0) $display("FAIL reset_mdbusy got %b want 0", bus.MDBusy);
    else pass_cnt++;
  endtask

  task automatic test_load_use();
    set_nop();
    bus.WriteReg_D = 5'd8;
    bus.Tnew_D     = 2'd2;
    #1;
    total_cnt++;
    if (bus.Stall_D !== 1'b0) $display("FAIL lw_issue_stall got %b want 0", bus.Stall_D);
    else pass_cnt++;
    tick();
    set_nop();
    bus.rs_D       = 5'd8;
    bus.Tuse_rs_D  = 2'd1;
    bus.WriteReg_D = 5'd10;
    bus.Tnew_D     = 2'd1;
    #1;
    total_cnt++;
    if (bus.Stall_D !== 1'b1) $display("FAIL load_use_stall got %b want 1", bus.Stall_D);
    else pass_cnt++;
    total_cnt++;
    if (bus.FlushE !== 1'b1) $display("FAIL load_use_flush got %b want 1", bus.FlushE);
    else pass_cnt++;
    tick();
    #1;
    total_cnt++;
    if (bus.Stall_D !== 1'b0) $display("FAIL load_use_release got %b want 0", bus.Stall_D);
    else pass_cnt++;
    total_cnt++;
    if (bus.MUX_RS_D_Sel !== 2'd0) $display("FAIL load_use_sel got %0d want 0", bus.MUX_RS_D_Sel);
    else pass_cnt++;
    drain();
  endtask

  // ALU result consumed by a branch in D: one stall, then forward from ALUOut_M.
  task automatic test_alu_branch(input bit use_rt);
    set_nop();
    bus.WriteReg_D = 5'd9;
    bus.Tnew_D     = 2'd1;
    tick();
    set_nop();
    if (use_rt) begin
      bus.rt_D      = 5'd9;
      bus.Tuse_rt_D = 2'd0;
    end else begin
      bus.rs_D      = 5'd9;
      bus.Tuse_rs_D = 2'd0;
    end
    #1;
    total_cnt++;
    if (bus.Stall_D !== 1'b1) $display("FAIL branch_stall rt=%0d got %b want 1", use_rt, bus.Stall_D);
    else pass_cnt++;
    tick();
    #1;
    total_cnt++;
    if (bus.Stall_D !== 1'b0) $display("FAIL branch_release rt=%0d got %b want 0", use_rt, bus.Stall_D);
    else pass_cnt++;
    total_cnt++;
    if ((use_rt ? bus.MUX_RT_D_Sel : bus.MUX_RS_D_Sel) !== 2'd1)
      $display("FAIL branch_fwd rt=%0d got rs=%0d rt=%0d want 1", use_rt,
               bus.MUX_RS_D_Sel, bus.MUX_RT_D_Sel);
    else pass_cnt++;
    total_cnt++;
    if ((use_rt ? bus.MUX_RS_D_Sel : bus.MUX_RT_D_Sel) !== 2'd0)
      $display("FAIL branch_other_sel rt=%0d got rs=%0d rt=%0d want 0", use_rt,
               bus.MUX_RS_D_Sel, bus.MUX_RT_D_Sel);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_link();
    set_nop();
    bus.WriteReg_D = 5'd31;
    bus.Tnew_D     = 2'd0;
    bus.LinkSrc_D  = 1'b1;
    tick();
    set_nop();
    tick();
    bus.rs_D      = 5'd31;
    bus.Tuse_rs_D = 2'd0;
    bus.rt_D      = 5'd31;
    bus.Tuse_rt_D = 2'd0;
    #1;
    total_cnt++;
    if (bus.Stall_D !== 1'b0) $display("FAIL jr_stall got %b want 0", bus.Stall_D);
    else pass_cnt++;
    total_cnt++;
    if (bus.MUX_RS_D_Sel !== 2'd2) $display("FAIL jr_rs_sel got %0d want 2", bus.MUX_RS_D_Sel);
    else pass_cnt++;
    total_cnt++;
    if (bus.MUX_RT_D_Sel !== 2'd2) $display("FAIL jr_rt_sel got %0d want 2", bus.MUX_RT_D_Sel);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_mdu_div();
    int stall_n = 0;
    int busy_n  = 0;
    set_nop();
    bus.MD_Start_D = 1'b1;
    bus.MD_Div_D   = 1'b1;
    bus.MD_Use_D   = 1'b1;
    #1;
    total_cnt++;
    if (bus.Stall_D !== 1'b0) $display("FAIL div_issue_stall got %b want 0", bus.Stall_D);
    else pass_cnt++;
    tick();
    set_nop();
    bus.MD_Use_D = 1'b1;
    #1;
    while (bus.Stall_D === 1'b1 && stall_n < 30) begin
      stall_n++;
      if (bus.MDBusy === 1'b1) busy_n++;
      tick();
    end
    total_cnt++;
    if (stall_n != 11) $display("FAIL mflo_stall_cycles got %0d want 11", stall_n);
    else pass_cnt++;
    total_cnt++;
    if (busy_n != 10) $display("FAIL div_busy_cycles got %0d want 10", busy_n);
    else pass_cnt++;
    total_cnt++;
    if (bus.MDBusy !== 1'b0) $display("FAIL div_busy_end got %b want 0", bus.MDBusy);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_zero_reg();
    set_nop();
    bus.WriteReg_D = 5'd0;
    bus.Tnew_D     = 2'd2;
    tick();
    set_nop();
    bus.Tuse_rs_D = 2'd0;
    bus.Tuse_rt_D = 2'd0;
    #1;
    total_cnt++;
    if (bus.Stall_D !== 1'b0) $display("FAIL zero_reg_stall got %b want 0", bus.Stall_D);
    else pass_cnt++;
    total_cnt++;
    if (bus.MUX_RS_D_Sel !== 2'd0) $display("FAIL zero_reg_sel got %0d want 0", bus.MUX_RS_D_Sel);
    else pass_cnt++;
    drain();
  endtask

  // A mult held in D by a load-use stall must not start the unit until it issues,
  // then a reset inside the busy window clears the counter.
  task automatic test_stalled_start_and_reset();
    set_nop();
    bus.WriteReg_D = 5'd8;
    bus.Tnew_D     = 2'd2;
    tick();
    set_nop();
    bus.rs_D       = 5'd8;
    bus.Tuse_rs_D  = 2'd1;
    bus.MD_Start_D = 1'b1;
    bus.MD_Use_D   = 1'b1;
    #1;
    total_cnt++;
    if (bus.Stall_D !== 1'b1) $display("FAIL mult_hold_stall got %b want 1", bus.Stall_D);
    else pass_cnt++;
    tick();
    #1;
    total_cnt++;
    if (bus.Stall_D !== 1'b0) $display("FAIL mult_no_start_recorded got %b want 0", bus.Stall_D);
    else pass_cnt++;
    tick();
    set_nop();
    tick();
    tick();
    #1;
    total_cnt++;
    if (bus.MDBusy !== 1'b1) $display("FAIL mult_busy got %b want 1", bus.MDBusy);
    else pass_cnt++;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
    total_cnt++;
    if (bus.MDBusy !== 1'b0) $display("FAIL reset_mid_busy got %b want 0", bus.MDBusy);
    else pass_cnt++;
    bus.MD_Use_D = 1'b1;
    #1;
    total_cnt++;
    if (bus.Stall_D !== 1'b0) $display("FAIL reset_mid_busy_stall got %b want 0", bus.Stall_D);
    else pass_cnt++;
    drain();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    RESET     = 1'b0;
    set_nop();
    test_reset();
    test_load_use();
    test_alu_branch(1'b0);
    test_alu_branch(1'b1);
    test_link();
    test_mdu_div();
    test_zero_reg();
    test_stalled_start_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
